// File: rtl/adc_ltc2308_ctrl.sv
// adc_ltc2308_ctrl: LTC2308 serial master running back-to-back convert/shift frames, emitting channel-tagged samples.
// Latency: a sample appears at ACQ entry; its tag is the channel requested one frame earlier (frame = CONV_CYCLES+24*CLK_DIV+ACQ_CYCLES).
// Backpressure: frames never stall; a sample still unconsumed when the next one lands is overwritten and sets sticky overrun.
// Build option: define ADC_AVG_EN to emit the mean of four consecutive same-channel samples instead of every raw code.

module adc_ltc2308_ctrl #(
  parameter int CLK_DIV     = 2,
  parameter int CONV_CYCLES = 80,
  parameter int ACQ_CYCLES  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [2:0]  channel,
  input  logic        unipolar,
  input  logic        overrun_clr,
  output logic        adc_cs,
  output logic        adc_sclk,
  output logic        adc_din,
  input  logic        adc_dout,
  output logic [11:0] sample_data,
  output logic [2:0]  sample_chan,
  output logic        sample_valid,
  input  logic        sample_ready,
  output logic        overrun,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_SHIFT, S_ACQ} state_t;

  localparam logic [15:0] CONV_LAST = 16'(CONV_CYCLES - 1);
  localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
  localparam logic [15:0] ACQ_LAST  = 16'(ACQ_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        phase_q, phase_d;        // 0 = SCLK low half, 1 = SCLK high half
  logic [3:0]  pulse_q, pulse_d;        // SCLK pulse index 0..11
  logic [5:0]  cfg_q, cfg_d;            // S/D, O/S, S1, S0, UNI, SLP
  logic [2:0]  cur_chan_q, cur_chan_d;  // channel configured by this frame's word
  logic [2:0]  prev_chan_q, prev_chan_d;// channel actually converted in this frame
  logic        first_q, first_d;        // config pipeline stale: drop this frame's word
  logic [11:0] shreg_q, shreg_d;

  logic [11:0] data_q, data_d;
  logic [2:0]  chan_q, chan_d;
  logic        valid_q, valid_d;
  logic        ovr_q, ovr_d;

  logic        acq_entry;
  logic        raw_load;
  logic        emit_vld;
  logic [11:0] emit_dat;
  logic [2:0]  emit_chan;
  logic [11:0] din_word;

  // Last SCLK high half of pulse 12 ends the shift phase; the word is complete here.
  assign acq_entry = (state_q == S_SHIFT) && phase_q && (cnt_q == DIV_LAST) && (pulse_q == 4'd11);
  assign raw_load  = acq_entry && !first_q;
  assign din_word  = {cfg_q, 6'b000000};

  assign adc_cs       = (state_q == S_CONV);
  assign adc_sclk     = (state_q == S_SHIFT) && phase_q;
  assign adc_din      = (state_q == S_SHIFT) ? din_word[4'd11 - pulse_q] : 1'b0;
  assign busy         = (state_q != S_IDLE);
  assign sample_data  = data_q;
  assign sample_chan  = chan_q;
  assign sample_valid = valid_q;
  assign overrun      = ovr_q;

  // Frame sequencer: next state, phase counters, config latch and serial capture.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    phase_d     = phase_q;
    pulse_d     = pulse_q;
    cfg_d       = cfg_q;
    cur_chan_d  = cur_chan_q;
    prev_chan_d = prev_chan_q;
    first_d     = first_q;
    shreg_d     = shreg_q;
    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d    = S_CONV;
          cnt_d      = '0;
          cfg_d      = {1'b1, channel[0], channel[2], channel[1], unipolar, 1'b0};
          cur_chan_d = channel;
          first_d    = 1'b1;  // previous config word is stale after idling
        end
      end
      S_CONV: begin
        if (cnt_q == CONV_LAST) begin
          state_d = S_SHIFT;
          cnt_d   = '0;
          phase_d = 1'b0;
          pulse_d = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_SHIFT: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (!phase_q) begin
            phase_d = 1'b1;
            shreg_d = {shreg_q[10:0], adc_dout};  // sample on the rising SCLK edge
          end else begin
            phase_d = 1'b0;
            if (pulse_q == 4'd11) begin
              state_d     = S_ACQ;
              prev_chan_d = cur_chan_q;
              first_d     = 1'b0;
            end else begin
              pulse_d = pulse_q + 4'd1;
            end
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_ACQ: begin
        if (cnt_q == ACQ_LAST) begin
          cnt_d = '0;
          if (enable) begin
            state_d    = S_CONV;
            cfg_d      = {1'b1, channel[0], channel[2], channel[1], unipolar, 1'b0};
            cur_chan_d = channel;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      phase_q     <= 1'b0;
      pulse_q     <= '0;
      cfg_q       <= '0;
      cur_chan_q  <= '0;
      prev_chan_q <= '0;
      first_q     <= 1'b1;
      shreg_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      phase_q     <= phase_d;
      pulse_q     <= pulse_d;
      cfg_q       <= cfg_d;
      cur_chan_q  <= cur_chan_d;
      prev_chan_q <= prev_chan_d;
      first_q     <= first_d;
      shreg_q     <= shreg_d;
    end
  end

`ifdef ADC_AVG_EN
  logic [13:0] acc_q, acc_d;
  logic [1:0]  acnt_q, acnt_d;
  logic [2:0]  achan_q, achan_d;
  logic [13:0] sum;

  // Four-sample averager; a channel change restarts the run, idling discards it.
  always_comb begin
    acc_d     = acc_q;
    acnt_d    = acnt_q;
    achan_d   = achan_q;
    sum       = acc_q + {2'b00, shreg_q};
    emit_vld  = 1'b0;
    emit_dat  = sum[13:2];
    emit_chan = prev_chan_q;
    if (state_q == S_IDLE) begin
      acc_d  = '0;
      acnt_d = '0;
    end else if (raw_load) begin
      if ((acnt_q != 2'd0) && (prev_chan_q != achan_q)) begin
        acc_d   = {2'b00, shreg_q};
        acnt_d  = 2'd1;
        achan_d = prev_chan_q;
      end else if (acnt_q == 2'd3) begin
        emit_vld = 1'b1;
        acc_d    = '0;
        acnt_d   = '0;
      end else begin
        acc_d   = sum;
        acnt_d  = acnt_q + 2'd1;
        achan_d = prev_chan_q;
      end
    end
  end

  // Averager registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q   <= '0;
      acnt_q  <= '0;
      achan_q <= '0;
    end else begin
      acc_q   <= acc_d;
      acnt_q  <= acnt_d;
      achan_q <= achan_d;
    end
  end
`else
  assign emit_vld  = raw_load;
  assign emit_dat  = shreg_q;
  assign emit_chan = prev_chan_q;
`endif

  // Output stream: load, handshake drop and sticky overrun (set beats clear).
  always_comb begin
    data_d  = data_q;
    chan_d  = chan_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (valid_q && sample_ready) valid_d = 1'b0;
    if (overrun_clr) ovr_d = 1'b0;
    if (emit_vld) begin
      data_d  = emit_dat;
      chan_d  = emit_chan;
      valid_d = 1'b1;
      if (valid_q && !sample_ready) ovr_d = 1'b1;
    end
  end

  // Output stream registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      chan_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      chan_q  <= chan_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

endmodule

// File: tb/tb_adc_ltc2308_ctrl.sv
// Bench for adc_ltc2308_ctrl: behavioural LTC2308 model plus frame-by-frame directed checks.
// Default parameters: frame = 80 CONV + 48 SHIFT + 4 ACQ = 132 cycles.
// Define ADC_AVG_EN to run the averaging sequence instead of the raw-sample sequences.

module tb_adc_ltc2308_ctrl;

  logic        clk = 1'b0;
  logic        reset, enable, unipolar, overrun_clr, sample_ready;
  logic [2:0]  channel;
  logic        adc_cs, adc_sclk, adc_din;
  logic        adc_dout = 1'b0;
  logic [11:0] sample_data;
  logic [2:0]  sample_chan;
  logic        sample_valid, overrun, busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  adc_ltc2308_ctrl dut (
    .clk(clk), .reset(reset), .enable(enable), .channel(channel), .unipolar(unipolar),
    .overrun_clr(overrun_clr), .adc_cs(adc_cs), .adc_sclk(adc_sclk), .adc_din(adc_din),
    .adc_dout(adc_dout), .sample_data(sample_data), .sample_chan(sample_chan),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .overrun(overrun), .busy(busy)
  );

  // ADC model: mode 0 returns const_code, mode 1 returns chan*0x100 of the previous frame's config.
  logic        model_mode = 1'b0;
  logic [11:0] const_code = 12'h000;
  logic [11:0] word = 12'h000;
  int          bit_idx = 0;
  logic        cs_prev = 1'b0, sclk_prev = 1'b0;
  int          cs_run = 0, cs_len = 0, pulses = 0, sclk_hi = 0;
  logic [11:0] din_bits = 12'h000;
  logic [11:0] next_word;

  assign next_word = (model_mode == 1'b0) ? const_code :
                     (pulses == 12) ? {1'b0, din_bits[9], din_bits[8], din_bits[10], 8'h00} : 12'hFFF;

  always @(posedge adc_cs or negedge adc_sclk) begin
    if (adc_cs) begin
      word     <= next_word;
      bit_idx  <= 11;
      adc_dout <= next_word[11];
    end else if (bit_idx > 0) begin
      bit_idx  <= bit_idx - 1;
      adc_dout <= word[bit_idx-1];
    end
  end

  // Pin monitor: CONVST width, SCLK pulses/high cycles and SDI bits of the current frame.
  always @(negedge clk) begin
    if (adc_cs && !cs_prev) begin
      cs_run <= 1; pulses <= 0; sclk_hi <= 0; din_bits <= 12'h000;
    end else begin
      if (adc_cs) cs_run <= cs_run + 1;
      else if (cs_run != 0) begin cs_len <= cs_run; cs_run <= 0; end
      if (adc_sclk) begin
        sclk_hi <= sclk_hi + 1;
        if (!sclk_prev) begin
          pulses   <= pulses + 1;
          din_bits <= {din_bits[10:0], adc_din};
        end
      end
    end
    cs_prev   <= adc_cs;
    sclk_prev <= adc_sclk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_cs_rise();
    int n = 0;
    while (adc_cs !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    if (adc_cs !== 1'b1) begin
      checks++; errors++;
      $display("FAIL cs_rise_timeout: adc_cs still %b after %0d cycles, expected 1", adc_cs, n);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {14'd0, adc_cs, adc_sclk, adc_din, sample_valid, overrun, busy, sample_data, sample_chan}, 32'd0);
  endtask

  typedef struct {
    logic [2:0]  ch;
    logic        uni;
    logic        exp_vld;
    logic [2:0]  exp_chan;
    logic [11:0] exp_dat;
    logic [5:0]  exp_cfg;
  } vec_t;

  vec_t tbl[6];

  initial begin
    reset = 1'b1; enable = 1'b0; channel = 3'd0; unipolar = 1'b0;
    overrun_clr = 1'b0; sample_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk_all_zero("reset_init");
    reset = 1'b0;
    @(negedge clk);

`ifdef ADC_AVG_EN
    begin
      logic [11:0] codes[5];
      codes[0] = 12'd0; codes[1] = 12'd100; codes[2] = 12'd101; codes[3] = 12'd102; codes[4] = 12'd105;
      model_mode = 1'b0; const_code = codes[0]; channel = 3'd0; enable = 1'b1;
      for (int i = 0; i < 5; i++) begin
        wait_cs_rise();
        if (i < 4) const_code = codes[i+1];
        repeat (128) @(negedge clk);
        if (i == 4) begin
          chk("avg_valid", {31'd0, sample_valid}, 32'd1);
          chk("avg_data", {20'd0, sample_data}, 32'd102);
          chk("avg_chan", {29'd0, sample_chan}, 32'd0);
        end else begin
          chk($sformatf("avg_novalid_f%0d", i), {31'd0, sample_valid}, 32'd0);
        end
      end
      enable = 1'b0;
    end
`else
    // Frame table: channel request per frame, expected emitted sample and SDI config bits.
    tbl[0] = '{3'd2, 1'b0, 1'b0, 3'd0, 12'h000, 6'b100100};
    tbl[1] = '{3'd2, 1'b0, 1'b1, 3'd2, 12'h200, 6'b100100};
    tbl[2] = '{3'd7, 1'b1, 1'b1, 3'd2, 12'h200, 6'b111110};
    tbl[3] = '{3'd4, 1'b0, 1'b1, 3'd7, 12'h700, 6'b101000};
    tbl[4] = '{3'd1, 1'b1, 1'b1, 3'd4, 12'h400, 6'b110010};
    tbl[5] = '{3'd6, 1'b0, 1'b1, 3'd1, 12'h100, 6'b101100};

    model_mode = 1'b1;
    channel = tbl[0].ch; unipolar = tbl[0].uni; enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wait_cs_rise();
      if (i < 5) begin channel = tbl[i+1].ch; unipolar = tbl[i+1].uni; end
      repeat (128) @(negedge clk);
      chk($sformatf("tbl%0d_valid", i), {31'd0, sample_valid}, {31'd0, tbl[i].exp_vld});
      if (tbl[i].exp_vld) begin
        chk($sformatf("tbl%0d_data", i), {20'd0, sample_data}, {20'd0, tbl[i].exp_dat});
        chk($sformatf("tbl%0d_chan", i), {29'd0, sample_chan}, {29'd0, tbl[i].exp_chan});
      end
      chk($sformatf("tbl%0d_din", i), {20'd0, din_bits}, {20'd0, tbl[i].exp_cfg, 6'b000000});
      chk($sformatf("tbl%0d_cs_len", i), cs_len, 32'd80);
      chk($sformatf("tbl%0d_pulses", i), pulses, 32'd12);
      chk($sformatf("tbl%0d_sclk_hi", i), sclk_hi, 32'd24);
      @(negedge clk);
      chk($sformatf("tbl%0d_valid_drop", i), {31'd0, sample_valid}, 32'd0);
    end

    // Overwrite with ready low: 0x111 then 0x222 on channel 6.
    model_mode = 1'b0; const_code = 12'h111; sample_ready = 1'b0;
    wait_cs_rise();
    const_code = 12'h222;
    repeat (128) @(negedge clk);
    chk("ovr_first_data", {20'd0, sample_data}, 32'h111);
    chk("ovr_first_flag", {31'd0, overrun}, 32'd0);
    wait_cs_rise();
    repeat (60) @(negedge clk);
    chk("ovr_hold_data", {19'd0, sample_valid, sample_data}, 32'h1111);
    repeat (68) @(negedge clk);
    chk("ovr_second_data", {20'd0, sample_data}, 32'h222);
    chk("ovr_second_chan", {29'd0, sample_chan}, 32'd6);
    chk("ovr_set", {30'd0, sample_valid, overrun}, 32'd3);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    chk("ovr_clear", {30'd0, sample_valid, overrun}, 32'd2);
    overrun_clr = 1'b1;
    wait_cs_rise();
    repeat (128) @(negedge clk);
    chk("ovr_set_beats_clr", {31'd0, overrun}, 32'd1);
    @(negedge clk);
    chk("ovr_clr_after", {31'd0, overrun}, 32'd0);
    overrun_clr = 1'b0;

    // Reset held 3 cycles in the middle of CONV while a sample is pending.
    wait_cs_rise();
    repeat (10) @(negedge clk);
    reset = 1'b1; enable = 1'b0;
    @(negedge clk);
    chk_all_zero("reset_mid_conv");
    repeat (2) @(negedge clk);
    reset = 1'b0; sample_ready = 1'b1;
    @(negedge clk);
    chk("reset_release_idle", {30'd0, busy, adc_cs}, 32'd0);

    // Channel 5 code 0xA5C; enable dropped during SHIFT pulse 3 of the second frame.
    const_code = 12'hA5C; channel = 3'd5; unipolar = 1'b0; enable = 1'b1;
    wait_cs_rise();
    repeat (128) @(negedge clk);
    chk("a5c_discard", {31'd0, sample_valid}, 32'd0);
    chk("a5c_din", {20'd0, din_bits}, 32'hE00);
    wait_cs_rise();
    repeat (89) @(negedge clk);
    chk("drop_pulses_before", pulses, 32'd2);
    enable = 1'b0;
    repeat (39) @(negedge clk);
    chk("drop_pulses_total", pulses, 32'd12);
    chk("drop_valid", {31'd0, sample_valid}, 32'd1);
    chk("drop_data", {20'd0, sample_data}, 32'hA5C);
    chk("drop_chan", {29'd0, sample_chan}, 32'd5);
    repeat (4) @(negedge clk);
    chk("drop_idle_busy", {31'd0, busy}, 32'd0);
    repeat (20) @(negedge clk);
    chk("drop_idle_stay", {30'd0, busy, adc_cs}, 32'd0);
    enable = 1'b1;
    wait_cs_rise();
    repeat (128) @(negedge clk);
    chk("reenable_discard", {31'd0, sample_valid}, 32'd0);
    wait_cs_rise();
    repeat (128) @(negedge clk);
    chk("reenable_sample", {16'd0, sample_valid, sample_chan, sample_data}, {16'd0, 1'b1, 3'd5, 12'hA5C});
    enable = 1'b0;
`endif

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
